scoot_drive_sequencer: RTL and testbench
========================================

Name: scoot_drive_sequencer

Overview:
- Downstream stage of the evolved gate-level robot controller; consumes its four combinational command lines.
- Those lines carry gate-delay glitches. This block synchronises and debounces them, then runs a ramped-PWM motor FSM.
- It drives left/right motor PWM, direction and brake to the chassis H-bridge.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a synchronised command must hold before acceptance (≥1).
- DUTY_W, 4: duty/PWM counter width; PWM period = 2^DUTY_W cycles.
- MAX_DUTY, 12: run duty, ≤ 2^DUTY_W-1.
- RAMP_STEP, 4: duty increment/decrement per ramp tick.
- RAMP_DIV, 2: cycles per ramp tick (≥1).
- BRAKE_CYCLES, 8: minimum cycles held in BRAKE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl0  in  1  controller output0: left motor request.
- ctrl1  in  1  controller output1: right motor request.
- ctrl2  in  1  controller output2: direction, 1 = reverse.
- ctrl3  in  1  controller output3: brake request.
- pwm_left  out  1  left motor PWM.
- pwm_right  out  1  right motor PWM.
- dir_out  out  1  applied direction.
- brake_out  out  1  H-bridge brake.
- cmd_strobe  out  1  one-cycle pulse on new accepted command.
- state  out  3  FSM state: IDLE=0, ACCEL=1, RUN=2, DECEL=3, BRAKE=4.
- duty  out  DUTY_W  current duty.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. While rst_n=0, every flop clears: all outputs 0, state=IDLE, acc_cmd=0, all counters 0. Reset asserted mid-operation forces this immediately, without waiting for a clock edge.
- Input synchroniser: {ctrl3..ctrl0} passes through a 2-flop synchroniser to form sync_cmd.
- Debounce counter: clears whenever sync_cmd differs from its previous-cycle value; otherwise increments, saturating.
- Command acceptance: when the count reaches STABLE_CYCLES-1 and sync_cmd ≠ acc_cmd, acc_cmd ← sync_cmd and cmd_strobe=1 for one cycle.
  - Latency from a ctrl edge to acc_cmd update: 2+STABLE_CYCLES cycles.
  - A pulse shorter than STABLE_CYCLES synchronised cycles is never accepted.
- Derived signals: motor_req = acc_cmd[0]|acc_cmd[1]; brk = acc_cmd[3]; want_dir = acc_cmd[2].
- Ramp tick: the tick counter clears on every state entry. A tick fires every RAMP_DIV-th cycle in ACCEL/DECEL; the first tick comes RAMP_DIV cycles after entry.
  - ACCEL: duty ← min(duty+RAMP_STEP, MAX_DUTY), computed at DUTY_W+1 bits, no wrap.
  - DECEL: duty ← max(duty-RAMP_STEP, 0), no underflow.
- FSM transitions: evaluated in priority order; brk wins over everything.
  - IDLE: duty=0. brk → BRAKE. Else motor_req → dir_out ← want_dir, ACCEL.
  - ACCEL: brk → BRAKE. !motor_req or want_dir≠dir_out → DECEL. Duty reaches MAX_DUTY → RUN.
  - RUN: brk → BRAKE. !motor_req or want_dir≠dir_out → DECEL.
  - DECEL: brk → BRAKE. duty==0 → IDLE. motor_req and want_dir==dir_out → ACCEL.
  - BRAKE: duty forced 0 on entry cycle; brake_out=1; brake counter runs. Leaves to IDLE only after BRAKE_CYCLES cycles AND brk=0; otherwise stays.
- Direction: dir_out changes only on the IDLE→ACCEL transition and never while duty>0. A reversal therefore always goes DECEL→IDLE→ACCEL.
- PWM: free-running DUTY_W-bit counter pwm_cnt wraps 2^DUTY_W-1→0; pwm_on = (pwm_cnt < duty).
  - pwm_left = pwm_on & acc_cmd[0] & !brake_out; pwm_right likewise with acc_cmd[1].
  - Releasing one side while the other is requested gates that side off immediately; no state change.
- Output timing: all outputs are registered except pwm_left/pwm_right, which are one AND level after registers.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously between edges → pwm_left, dir_out, duty, state all 0 before the next clk edge; held until release.
- Glitch rejection: ctrl0 high for 2 cycles then low → cmd_strobe never asserts, state stays IDLE, duty=0.
- Forward accel: ctrl0=1 held → cmd_strobe 6 cycles later, ACCEL, duty 0→4→8→12 on ticks every 2 cycles, then RUN. In RUN, pwm_left high 12 of every 16 cycles; pwm_right=0.
- Reversal: in RUN, set ctrl2=1 → DECEL with duty 12→8→4→0, IDLE, dir_out=1, ACCEL back to 12; dir_out never toggles while duty>0.
- Brake priority: ctrl3=1 during ACCEL at duty=4 → BRAKE, duty=0, brake_out=1, pwm outputs 0.
  - Release ctrl3 after 3 cycles → stays in BRAKE until 8 cycles elapsed, then IDLE.
- Saturation: MAX_DUTY=10, RAMP_STEP=4 → ramp-up duty 0,4,8,10; ramp-down 10,6,2,0; no wrap past 15 or below 0.

Source files
------------

// File: rtl/scoot_drive_sequencer.sv
// Synchronises and debounces the four controller command lines, then runs a ramped-PWM motor FSM.
// Latency: ctrl edge to accepted command 2+STABLE_CYCLES cycles; FSM reacts one cycle later. No backpressure.
module scoot_drive_sequencer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DUTY_W        = 4,
    parameter int unsigned MAX_DUTY      = 12,
    parameter int unsigned RAMP_STEP     = 4,
    parameter int unsigned RAMP_DIV      = 2,
    parameter int unsigned BRAKE_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl0,
    input  logic              ctrl1,
    input  logic              ctrl2,
    input  logic              ctrl3,
    output logic              pwm_left,
    output logic              pwm_right,
    output logic              dir_out,
    output logic              brake_out,
    output logic              cmd_strobe,
    output logic [2:0]        state,
    output logic [DUTY_W-1:0] duty
);

    localparam int unsigned DEB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TICK_W = $clog2(RAMP_DIV + 1);
    localparam int unsigned BRK_W  = $clog2(BRAKE_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(STABLE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [BRK_W-1:0]  BRK_LAST  = BRK_W'(BRAKE_CYCLES - 1);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W + 1)'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCEL = 3'd1,
        S_RUN   = 3'd2,
        S_DECEL = 3'd3,
        S_BRAKE = 3'd4
    } state_t;

    logic [3:0]        sync_meta;
    logic [3:0]        sync_cmd;
    logic [3:0]        acc_cmd;
    logic [DEB_W-1:0]  deb_cnt;

    // The debounce compares the value about to enter sync_cmd with sync_cmd itself,
    // so the stability count is already valid on the cycle sync_cmd settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= '0;
            sync_cmd   <= '0;
            deb_cnt    <= '0;
            acc_cmd    <= '0;
            cmd_strobe <= 1'b0;
        end else begin
            sync_meta  <= {ctrl3, ctrl2, ctrl1, ctrl0};
            sync_cmd   <= sync_meta;
            cmd_strobe <= 1'b0;
            if (sync_meta != sync_cmd)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_LAST)
                deb_cnt <= deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST && sync_cmd != acc_cmd) begin
                acc_cmd    <= sync_cmd;
                cmd_strobe <= 1'b1;
            end
        end
    end

    logic motor_req;
    logic brk;
    logic want_dir;
    assign motor_req = acc_cmd[0] | acc_cmd[1];
    assign brk       = acc_cmd[3];
    assign want_dir  = acc_cmd[2];

    state_t             cur;
    state_t             nxt;
    logic [DUTY_W-1:0]  duty_q;
    logic [DUTY_W-1:0]  duty_nxt;
    logic               dir_q;
    logic               dir_nxt;
    logic               brake_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BRK_W-1:0]   brk_cnt;
    logic [DUTY_W-1:0]  pwm_cnt;

    logic               ramping;
    logic               tick;
    logic               brake_done;
    logic [DUTY_W:0]    up_sum;
    logic [DUTY_W-1:0]  up_val;
    logic [DUTY_W-1:0]  dn_val;
    logic [DUTY_W-1:0]  step_val;

    assign ramping    = (cur == S_ACCEL) || (cur == S_DECEL);
    assign tick       = ramping && (tick_cnt == TICK_LAST);
    assign brake_done = (brk_cnt == BRK_LAST);

    // Ramp arithmetic is one bit wider than duty so the clamp sees overflow.
    assign up_sum   = {1'b0, duty_q} + STEP_X;
    assign up_val   = (up_sum > MAX_X) ? MAX_D : up_sum[DUTY_W-1:0];
    assign dn_val   = ({1'b0, duty_q} < STEP_X) ? '0 : (duty_q - STEP_X[DUTY_W-1:0]);
    assign step_val = !tick ? duty_q : ((cur == S_DECEL) ? dn_val : up_val);

    always_comb begin
        nxt      = cur;
        duty_nxt = duty_q;
        dir_nxt  = dir_q;
        case (cur)
            S_IDLE: begin
                duty_nxt = '0;
                if (brk) begin
                    nxt = S_BRAKE;
                end else if (motor_req) begin
                    nxt     = S_ACCEL;
                    dir_nxt = want_dir;
                end
            end
            S_ACCEL: begin
                if (brk) begin
                    nxt = S_BRAKE;
                end else if (!motor_req || want_dir != dir_q) begin
                    nxt = S_DECEL;
                end else begin
                    duty_nxt = step_val;
                    if (step_val == MAX_D)
                        nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (brk)
                    nxt = S_BRAKE;
                else if (!motor_req || want_dir != dir_q)
                    nxt = S_DECEL;
            end
            S_DECEL: begin
                if (brk) begin
                    nxt = S_BRAKE;
                end else begin
                    duty_nxt = step_val;
                    if (step_val == '0)
                        nxt = S_IDLE;
                    else if (motor_req && want_dir == dir_q)
                        nxt = S_ACCEL;
                end
            end
            S_BRAKE: begin
                duty_nxt = '0;
                if (brake_done && !brk)
                    nxt = S_IDLE;
            end
            default: begin
                nxt      = S_IDLE;
                duty_nxt = '0;
            end
        endcase
        if (nxt == S_BRAKE)
            duty_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= S_IDLE;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            brake_q  <= 1'b0;
            tick_cnt <= '0;
            brk_cnt  <= '0;
            pwm_cnt  <= '0;
        end else begin
            cur     <= nxt;
            duty_q  <= duty_nxt;
            dir_q   <= dir_nxt;
            brake_q <= (nxt == S_BRAKE);
            pwm_cnt <= pwm_cnt + 1'b1;
            if (nxt != cur)
                tick_cnt <= '0;
            else if (ramping)
                tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
            if (nxt != cur)
                brk_cnt <= '0;
            else if (cur == S_BRAKE && !brake_done)
                brk_cnt <= brk_cnt + 1'b1;
        end
    end

    logic pwm_on;
    assign pwm_on    = (pwm_cnt < duty_q);
    assign pwm_left  = pwm_on & acc_cmd[0] & ~brake_q;
    assign pwm_right = pwm_on & acc_cmd[1] & ~brake_q;
    assign dir_out   = dir_q;
    assign brake_out = brake_q;
    assign state     = cur;
    assign duty      = duty_q;

endmodule

// File: tb/tb_scoot_drive_sequencer.sv
// Directed bench for scoot_drive_sequencer: default instance plus a MAX_DUTY=10 instance sharing the inputs.
module tb_scoot_drive_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic ctrl0, ctrl1, ctrl2, ctrl3;

    logic       pwm_left, pwm_right, dir_out, brake_out, cmd_strobe;
    logic [2:0] state;
    logic [3:0] duty;

    logic       pwm_left2, pwm_right2, dir_out2, brake_out2, cmd_strobe2;
    logic [2:0] state2;
    logic [3:0] duty2;

    int vectors = 0;
    int miscompares = 0;
    int hl, hr, h2;
    int dir_viol = 0;
    logic seen;
    logic prev_dir = 1'b0;
    logic [3:0] prev_duty = '0;

    always #5 clk = ~clk;

    scoot_drive_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3),
        .pwm_left(pwm_left), .pwm_right(pwm_right), .dir_out(dir_out),
        .brake_out(brake_out), .cmd_strobe(cmd_strobe), .state(state), .duty(duty)
    );

    scoot_drive_sequencer #(.MAX_DUTY(10)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3),
        .pwm_left(pwm_left2), .pwm_right(pwm_right2), .dir_out(dir_out2),
        .brake_out(brake_out2), .cmd_strobe(cmd_strobe2), .state(state2), .duty(duty2)
    );

    // Direction must never move while the previous sample had nonzero duty.
    always @(negedge clk) begin
        if (rst_n && dir_out !== prev_dir && prev_duty != 4'd0)
            dir_viol <= dir_viol + 1;
        prev_dir  <= dir_out;
        prev_duty <= duty;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {ctrl3, ctrl2, ctrl1, ctrl0} = 4'b0000;
        cyc(2);
        chk("rst_state", state, 0);
        chk("rst_duty", duty, 0);
        chk("rst_pwm_l", pwm_left, 0);
        chk("rst_pwm_r", pwm_right, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_brake", brake_out, 0);
        chk("rst_strobe", cmd_strobe, 0);
        rst_n = 1'b1;
        cyc(3);

        // Two-cycle glitch on ctrl0 must be rejected.
        ctrl0 = 1'b1;
        cyc(2);
        ctrl0 = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            cyc(1);
            seen = seen | cmd_strobe;
        end
        chk("glitch_strobe", seen, 0);
        chk("glitch_state", state, 0);
        chk("glitch_duty", duty, 0);

        // Forward acceleration.
        ctrl0 = 1'b1;
        cyc(6);
        chk("fwd_strobe", cmd_strobe, 1);
        chk("fwd_state_idle", state, 0);
        cyc(1);
        chk("fwd_strobe_pulse", cmd_strobe, 0);
        chk("fwd_accel", state, 1);
        chk("fwd_duty0", duty, 0);
        chk("fwd_dir", dir_out, 0);
        cyc(2);
        chk("fwd_duty4", duty, 4);
        chk("sat_duty4", duty2, 4);
        cyc(2);
        chk("fwd_duty8", duty, 8);
        chk("sat_duty8", duty2, 8);
        cyc(2);
        chk("fwd_duty12", duty, 12);
        chk("fwd_run", state, 2);
        chk("sat_duty10", duty2, 10);
        chk("sat_run", state2, 2);
        hl = 0; hr = 0; h2 = 0;
        repeat (16) begin
            cyc(1);
            hl += int'(pwm_left);
            hr += int'(pwm_right);
            h2 += int'(pwm_left2);
        end
        chk("run_pwm_left_hi", hl, 12);
        chk("run_pwm_right_hi", hr, 0);
        chk("sat_pwm_left_hi", h2, 10);

        // Reversal: ramp down, pass through IDLE, ramp up reversed.
        ctrl2 = 1'b1;
        cyc(6);
        chk("rev_strobe", cmd_strobe, 1);
        chk("rev_still_run", state, 2);
        cyc(1);
        chk("rev_decel", state, 3);
        chk("rev_duty12", duty, 12);
        chk("rev_dir_hold", dir_out, 0);
        chk("sat_decel", state2, 3);
        cyc(2);
        chk("rev_duty8", duty, 8);
        chk("sat_duty6", duty2, 6);
        cyc(2);
        chk("rev_duty4", duty, 4);
        chk("sat_duty2", duty2, 2);
        chk("rev_dir_hold2", dir_out, 0);
        cyc(2);
        chk("rev_duty0", duty, 0);
        chk("rev_idle", state, 0);
        chk("sat_duty0", duty2, 0);
        chk("sat_idle", state2, 0);
        cyc(1);
        chk("rev_accel", state, 1);
        chk("rev_dir", dir_out, 1);
        cyc(6);
        chk("rev_duty12_up", duty, 12);
        chk("rev_run", state, 2);

        // Stop, then set up brake during ACCEL at duty 4.
        {ctrl3, ctrl2, ctrl1, ctrl0} = 4'b0000;
        cyc(20);
        chk("stop_idle", state, 0);
        chk("stop_duty", duty, 0);

        ctrl0 = 1'b1;
        cyc(4);
        ctrl3 = 1'b1;
        cyc(4);
        ctrl3 = 1'b0;
        ctrl2 = 1'b1;
        chk("brk_pre_accel", state, 1);
        chk("brk_pre_duty", duty, 0);
        cyc(1);
        chk("brk_accel_d4", duty, 4);
        cyc(1);
        chk("brk_strobe", cmd_strobe, 1);
        chk("brk_accel_hold", state, 1);
        chk("brk_duty_hold", duty, 4);
        cyc(1);
        chk("brk_state", state, 4);
        chk("brk_duty", duty, 0);
        chk("brk_out", brake_out, 1);
        chk("brk_pwm_l", pwm_left, 0);
        chk("brk_pwm_r", pwm_right, 0);
        cyc(3);
        chk("brk_release_strobe", cmd_strobe, 1);
        chk("brk_release_hold", state, 4);
        cyc(4);
        chk("brk_min_hold", state, 4);
        chk("brk_min_out", brake_out, 1);
        cyc(1);
        chk("brk_exit_idle", state, 0);
        chk("brk_exit_out", brake_out, 0);
        cyc(1);
        chk("post_brk_accel", state, 1);
        chk("post_brk_dir", dir_out, 1);
        cyc(6);
        chk("post_brk_run", state, 2);
        chk("post_brk_duty", duty, 12);
        chk("dir_never_moved_loaded", dir_viol, 0);

        // Asynchronous reset in RUN, applied between clock edges.
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_duty", duty, 0);
        chk("arst_dir", dir_out, 0);
        chk("arst_pwm_l", pwm_left, 0);
        chk("arst_brake", brake_out, 0);
        cyc(3);
        chk("arst_hold_state", state, 0);
        chk("arst_hold_duty", duty, 0);
        chk("arst_hold_dir", dir_out, 0);
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
